// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM states and the byte-lane strobe helper.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

   // Little-endian byte strobes for a transfer of size hsize at byte offset a.
   function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] a);
      logic [3:0] m;
      case (hsize)
         HSIZE_BYTE: m = 4'b0001 << a;
         HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_sram_bytewe.sv
// DEPTH x 32 word memory: one byte-enabled synchronous write port and one
// combinational read port (separate addresses so back-to-back write/read work).
module ahb_sram_bytewe #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane write; lanes with we=0 keep their content.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem_param.sv
// AHB slave with internal word memory, programmable wait states and a
// two-cycle ERROR response for illegal size/alignment/range transfers.
module ahb_slave_mem_param
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hsel,
   input  logic              hready_in,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [ADDR_W-1:0] haddr_mux_out,
   input  logic [31:0]       hwdata_mux_out,
   output logic [31:0]       hrdata,
   output logic              hready,
   output logic [1:0]        hresp,
   output logic [15:0]       hsplit
);

   localparam int IW = $clog2(MEM_DEPTH);
   localparam int AW = IW + 2;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]  lo_q, lo_d;
   logic        wr_q, wr_d;
   logic [2:0]  size_q, size_d;
   logic        cmp_q, cmp_d;     // current cycle completes a legal data phase
   logic        hready_q, hready_d;
   logic [1:0]  hresp_q, hresp_d;
   logic [31:0] hrdata_q, hrdata_d;

   logic          acc, legal, commit, fwd_hit;
   logic [IW-1:0] new_idx, rd_idx;
   logic [3:0]    we_lane;
   logic [31:0]   mem_rdata, rd_word;

   assign acc = hsel && hready_in && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
   assign new_idx = haddr_mux_out[AW-1:2];
   assign legal = (hsize <= HSIZE_WORD)
               && !(hsize == HSIZE_HALF && haddr_mux_out[0])
               && !(hsize == HSIZE_WORD && haddr_mux_out[1:0] != 2'b00)
               && ((haddr_mux_out >> AW) == '0);

   // A write commits at the edge closing its completing (hready=1) cycle.
   assign commit  = cmp_q && wr_q;
   assign we_lane = commit ? lane_mask(size_q, lo_q) : 4'b0000;
   // While waiting, the read word is the captured one; otherwise it is the
   // word being captured now (zero-wait path).
   assign rd_idx  = (state_q == ST_WAIT) ? idx_q : new_idx;
   assign fwd_hit = commit && (idx_q == rd_idx);

   ahb_sram_bytewe #(.DEPTH(MEM_DEPTH), .AW(IW)) u_mem (
      .clk   (hclk),
      .we    (we_lane & {4{hresetn}}),
      .waddr (idx_q),
      .wdata (hwdata_mux_out),
      .raddr (rd_idx),
      .rdata (mem_rdata)
   );

   // Read data with per-lane forwarding of a write committing on the same edge.
   always_comb begin
      rd_word = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (fwd_hit && we_lane[i]) rd_word[8*i +: 8] = hwdata_mux_out[8*i +: 8];
      end
   end

   // Next-state, capture and registered-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lo_d     = lo_q;
      wr_d     = wr_q;
      size_d   = size_q;
      cmp_d    = 1'b0;
      hready_d = 1'b1;
      hresp_d  = HRESP_OKAY;
      hrdata_d = hrdata_q;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (acc) begin
               idx_d  = new_idx;
               lo_d   = haddr_mux_out[1:0];
               wr_d   = hwrite;
               size_d = hsize;
               if (!legal) begin
                  state_d  = ST_ERR1;
                  hready_d = 1'b0;
                  hresp_d  = HRESP_ERROR;
               end else if (WAIT_STATES > 0) begin
                  state_d  = ST_WAIT;
                  cnt_d    = WS_LOAD;
                  hready_d = 1'b0;
               end else begin
                  cmp_d = 1'b1;
                  if (!hwrite) hrdata_d = rd_word;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               cmp_d   = 1'b1;
               if (!wr_q) hrdata_d = rd_word;
            end else begin
               cnt_d    = cnt_q - 4'd1;
               hready_d = 1'b0;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
            hresp_d = HRESP_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         lo_q     <= 2'b00;
         wr_q     <= 1'b0;
         size_q   <= 3'b000;
         cmp_q    <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         hrdata_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lo_q     <= lo_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         cmp_q    <= cmp_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         hrdata_q <= hrdata_d;
      end
   end

   assign hready = hready_q;
   assign hresp  = hresp_q;
   assign hrdata = hrdata_q;
   assign hsplit = 16'h0000;

endmodule

// File: tb/tb_ahb_slave_mem_param.sv
// Bench: zero-wait instance driven from a cycle table, three-wait instance
// exercised by hand-written sequences (wait timing, reset mid-wait).
module tb_ahb_slave_mem_param;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel0, hsel3;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] haddr, hwdata;

   logic [31:0] hrdata0, hrdata3;
   logic        hready0, hready3;
   logic [1:0]  hresp0, hresp3;
   logic [15:0] hsplit0, hsplit3;

   int nerr = 0;
   int nchk = 0;

   always #5 hclk = ~hclk;

   ahb_slave_mem_param #(.ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hready_in(hready0),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .haddr_mux_out(haddr),
      .hwdata_mux_out(hwdata), .hrdata(hrdata0), .hready(hready0),
      .hresp(hresp0), .hsplit(hsplit0));

   ahb_slave_mem_param #(.ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u3 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .hready_in(hready3),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .haddr_mux_out(haddr),
      .hwdata_mux_out(hwdata), .hrdata(hrdata3), .hready(hready3),
      .hresp(hresp3), .hsplit(hsplit3));

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rdy;
      logic [1:0]  resp;
      logic        chk;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rdy, input logic [1:0] resp, input logic chk,
                      input logic [31:0] rd);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
      v.wd = wd; v.rdy = rdy; v.resp = resp; v.chk = chk; v.rd = rd;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'b010; haddr = 32'h0;
   endtask

   // One transfer on the three-wait instance; counts hready-low data-phase
   // cycles (bounded) and returns hrdata from the completing cycle.
   task automatic ws3_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           output int lows, output logic [31:0] rd, output logic [1:0] resp);
      hsel3 = 1'b1; htrans = 2'b10; hwrite = wr; hsize = 3'b010; haddr = addr;
      @(posedge hclk); #1;
      drive_idle();
      hwdata = wd;
      lows = 0;
      while (!hready3 && lows < 20) begin
         lows++;
         @(posedge hclk); #1;
      end
      rd = hrdata3;
      resp = hresp3;
      @(posedge hclk); #1;
   endtask

   initial begin
      int lows;
      logic [31:0] rd;
      logic [1:0]  resp;

      //   sel trans  wr size    addr      wdata          rdy resp  chk rdata
      add(1, 2'b10, 1, 3'b010, 32'h00,  32'h0,          1, 2'b00, 0, 32'h0);
      add(1, 2'b10, 1, 3'b010, 32'h10,  32'h5A5A5A5A,   1, 2'b00, 0, 32'h0);
      add(1, 2'b10, 0, 3'b010, 32'h10,  32'hDEADBEEF,   1, 2'b00, 1, 32'hDEADBEEF);
      add(1, 2'b10, 1, 3'b010, 32'h20,  32'h0,          1, 2'b00, 0, 32'h0);
      add(1, 2'b11, 1, 3'b000, 32'h21,  32'h11223344,   1, 2'b00, 0, 32'h0);
      add(1, 2'b11, 1, 3'b001, 32'h22,  32'h0000AA00,   1, 2'b00, 0, 32'h0);
      add(1, 2'b10, 0, 3'b010, 32'h20,  32'hBBCC0000,   1, 2'b00, 1, 32'hBBCCAA44);
      add(1, 2'b00, 0, 3'b010, 32'h20,  32'h0,          1, 2'b00, 1, 32'hBBCCAA44);
      add(1, 2'b10, 0, 3'b010, 32'h20,  32'h0,          1, 2'b00, 1, 32'hBBCCAA44);
      add(1, 2'b10, 1, 3'b010, 32'h02,  32'h0,          0, 2'b01, 1, 32'hBBCCAA44);
      add(1, 2'b10, 1, 3'b010, 32'h00,  32'hFFFFFFFF,   1, 2'b01, 0, 32'h0);
      add(1, 2'b10, 0, 3'b010, 32'h10,  32'hFFFFFFFF,   1, 2'b00, 1, 32'hDEADBEEF);
      add(1, 2'b10, 1, 3'b011, 32'h10,  32'h0,          0, 2'b01, 0, 32'h0);
      add(1, 2'b00, 0, 3'b010, 32'h0,   32'h0,          1, 2'b01, 1, 32'hDEADBEEF);
      add(1, 2'b10, 1, 3'b010, 32'h400, 32'h0,          0, 2'b01, 0, 32'h0);
      add(1, 2'b00, 0, 3'b010, 32'h0,   32'hFFFFFFFF,   1, 2'b01, 0, 32'h0);
      add(0, 2'b10, 1, 3'b010, 32'h10,  32'h0,          1, 2'b00, 0, 32'h0);
      add(1, 2'b01, 1, 3'b010, 32'h10,  32'hFFFFFFFF,   1, 2'b00, 0, 32'h0);
      add(1, 2'b00, 1, 3'b010, 32'h10,  32'hFFFFFFFF,   1, 2'b00, 0, 32'h0);
      add(1, 2'b10, 0, 3'b010, 32'h10,  32'hFFFFFFFF,   1, 2'b00, 1, 32'hDEADBEEF);
      add(1, 2'b10, 0, 3'b010, 32'h00,  32'h0,          1, 2'b00, 1, 32'h5A5A5A5A);
      add(1, 2'b00, 0, 3'b010, 32'h00,  32'h0,          1, 2'b00, 1, 32'h5A5A5A5A);

      hresetn = 1'b0;
      hwdata  = 32'h0;
      drive_idle();
      repeat (2) @(posedge hclk);
      #1;
      check("rst u0 hready", 32'(hready0), 32'h1);
      check("rst u0 hresp",  32'(hresp0),  32'h0);
      check("rst u0 hrdata", hrdata0,      32'h0);
      check("rst u3 hready", 32'(hready3), 32'h1);
      check("rst u3 hrdata", hrdata3,      32'h0);
      hresetn = 1'b1;
      @(posedge hclk); #1;

      for (int i = 0; i < tbl.size(); i++) begin
         hsel0  = tbl[i].sel;
         htrans = tbl[i].trans;
         hwrite = tbl[i].wr;
         hsize  = tbl[i].size;
         haddr  = tbl[i].addr;
         hwdata = tbl[i].wd;
         @(posedge hclk); #1;
         check($sformatf("row%0d hready", i), 32'(hready0), 32'(tbl[i].rdy));
         check($sformatf("row%0d hresp", i),  32'(hresp0),  32'(tbl[i].resp));
         check($sformatf("row%0d hsplit", i), 32'(hsplit0), 32'h0);
         if (tbl[i].chk) check($sformatf("row%0d hrdata", i), hrdata0, tbl[i].rd);
      end
      drive_idle();
      hwdata = 32'h0;
      @(posedge hclk); #1;

      // Three wait states: write then read back, 3 low cycles each.
      ws3_xfer(1'b1, 32'h04, 32'hCAFEF00D, lows, rd, resp);
      check("ws3 write lows", 32'(lows), 32'd3);
      check("ws3 write resp", 32'(resp), 32'h0);
      ws3_xfer(1'b0, 32'h04, 32'h0, lows, rd, resp);
      check("ws3 read lows",  32'(lows), 32'd3);
      check("ws3 read data",  rd,        32'hCAFEF00D);
      check("ws3 read resp",  32'(resp), 32'h0);

      // Reset in the middle of a waited write: aborted, memory untouched.
      hsel3 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h04;
      @(posedge hclk); #1;
      drive_idle();
      hwdata = 32'h12345678;
      check("midwait hready", 32'(hready3), 32'h0);
      hresetn = 1'b0;
      @(posedge hclk); #1;
      check("midrst hready", 32'(hready3), 32'h1);
      check("midrst hresp",  32'(hresp3),  32'h0);
      check("midrst hrdata", hrdata3,      32'h0);
      @(posedge hclk); #1;
      hresetn = 1'b1;
      ws3_xfer(1'b0, 32'h04, 32'h0, lows, rd, resp);
      check("postrst lows", 32'(lows), 32'd3);
      check("postrst data", rd,        32'hCAFEF00D);
      check("u3 hsplit",    32'(hsplit3), 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
